// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA stream FIFO: transfer size and threshold encodings.
package dma_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        FTH_QUARTER  = 2'd0,
        FTH_HALF     = 2'd1,
        FTH_3QUARTER = 2'd2,
        FTH_FULL     = 2'd3
    } fth_e;

    // The reserved code 3 behaves as a word so a bad size can never stall the stream.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] code);
        logic [2:0] n;
        case (code)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dma_fifo_ram.sv
// Byte-lane storage for dma_fifo: 4-byte wrapping write port with byte enables and
// 4-byte wrapping combinational read port masked to the bytes actually held.
module dma_fifo_ram #(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  logic [2:0]    wr_nbytes,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] rd_ptr,
    input  logic [2:0]    rd_avail,
    output logic [31:0]   rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0] mem [DEPTH];

    // No reset on the array: contents are only observable once the count covers them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < wr_nbytes) begin
                    mem[wr_ptr + AW'(k)] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < rd_avail) begin
                rdata[8*k +: 8] = mem[rd_ptr + AW'(k)];
            end
        end
    end

endmodule

// File: rtl/dma_fifo.sv
// Byte-granular stream FIFO between dma_ctrl source and destination masters.
// Optional sticky overflow/underflow flag enabled by defining DMA_FIFO_ERR_EN.
module dma_fifo
    import dma_pkg::*;
#(
    parameter int unsigned fifo_size_exp = 5
) (
    input  logic                   i_clk,
    input  logic                   i_nreset,
    input  logic                   i_flush,
    input  logic                   i_put,
    input  logic [1:0]             i_numb_bytes_put,
    input  logic [31:0]            i_wdata,
    input  logic                   i_pull,
    input  logic [1:0]             i_numb_bytes_pull,
    output logic [31:0]            o_rdata,
    output logic [fifo_size_exp:0] o_left_put,
    output logic [fifo_size_exp:0] o_left_pull,
    output logic                   o_empty,
    output logic                   o_full,
    input  logic [1:0]             i_fth,
    output logic                   o_thresh,
    output logic                   o_err,
    input  logic                   i_err_clr
);

    localparam int unsigned E = fifo_size_exp;
    localparam logic [E:0] DEPTH_C = {1'b1, {E{1'b0}}};

    logic [E-1:0] wr_ptr, rd_ptr;
    logic [E:0]   count, count_next;
    logic [E:0]   free_cnt;
    logic [E:0]   n_put_w, n_pull_w;
    logic [2:0]   n_put, n_pull;
    logic         put_acc, pull_acc;
    logic [2:0]   rd_avail;
    logic [E:0]   thr;

    assign n_put  = size_to_nbytes(i_numb_bytes_put);
    assign n_pull = size_to_nbytes(i_numb_bytes_pull);

    always_comb begin
        n_put_w       = '0;
        n_put_w[2:0]  = n_put;
        n_pull_w      = '0;
        n_pull_w[2:0] = n_pull;
    end

    assign free_cnt = DEPTH_C - count;
    assign put_acc  = i_put  && (n_put_w  <= free_cnt);
    assign pull_acc = i_pull && (n_pull_w <= count);

    always_comb begin
        count_next = count;
        if (put_acc)  count_next = count_next + n_put_w;
        if (pull_acc) count_next = count_next - n_pull_w;
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (put_acc)  wr_ptr <= wr_ptr + n_put_w[E-1:0];
            if (pull_acc) rd_ptr <= rd_ptr + n_pull_w[E-1:0];
            count <= count_next;
        end
    end

    assign rd_avail = (count >= 4) ? 3'd4 : count[2:0];

    dma_fifo_ram #(.AW(E)) u_ram (
        .clk       (i_clk),
        .wr_en     (put_acc && !i_flush),
        .wr_ptr    (wr_ptr),
        .wr_nbytes (n_put),
        .wdata     (i_wdata),
        .rd_ptr    (rd_ptr),
        .rd_avail  (rd_avail),
        .rdata     (o_rdata)
    );

    always_comb begin
        case (fth_e'(i_fth))
            FTH_QUARTER:  thr = DEPTH_C >> 2;
            FTH_HALF:     thr = DEPTH_C >> 1;
            FTH_3QUARTER: thr = (DEPTH_C >> 1) + (DEPTH_C >> 2);
            default:      thr = DEPTH_C;
        endcase
    end

    assign o_left_put  = free_cnt;
    assign o_left_pull = count;
    assign o_empty     = (count == '0);
    assign o_full      = (count == DEPTH_C);
    assign o_thresh    = (count >= thr);

`ifdef DMA_FIFO_ERR_EN
    logic err_q;
    logic reject;

    // Operations discarded by a flush are not rejections.
    assign reject = !i_flush && ((i_put && !put_acc) || (i_pull && !pull_acc));

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            err_q <= 1'b0;
        end else if (reject) begin
            err_q <= 1'b1;
        end else if (i_err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign o_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_err = 1'b0;
`endif

endmodule
